// File: rtl/aes_pkg.sv
// AES-128 decryption shared types and constants.
// Buffer entry layout for the AddRoundKey output stage.
package aes_pkg;

  localparam int TEXT_WIDTH     = 128;
  localparam int BYTE_WIDTH     = 8;
  localparam int NUM_ROUNDS     = 10;
  localparam int KEY_ADDR_WIDTH = 4;

  typedef struct packed {
    logic [TEXT_WIDTH-1:0]     state;
    logic [KEY_ADDR_WIDTH-1:0] round;
    logic                      last;
  } buf_entry_t;

  localparam int ENTRY_WIDTH = $bits(buf_entry_t);

endpackage

// File: rtl/aes_skid_fifo.sv
// Two-entry FIFO with a registered ready.
// Ready also folds in an external permit (allow_i).
module aes_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             allow_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign push = push_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push & ~pop: count_d = count_q + 2'd1;
      pop & ~push: count_d = count_q - 2'd1;
      default:     count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_o <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      count_q    <= count_d;
      in_ready_o <= allow_i && (count_d != 2'd2);
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign data_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/inv_add_round_key.sv
// AES-128 decrypt AddRoundKey stage: XORs each beat with the
// round key, walking rounds down from NUM_ROUNDS to 0.
import aes_pkg::*;

module inv_add_round_key #(
  parameter int TEXT_WIDTH     = aes_pkg::TEXT_WIDTH,
  parameter int NUM_ROUNDS     = aes_pkg::NUM_ROUNDS,
  parameter int KEY_ADDR_WIDTH = aes_pkg::KEY_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      key_we_i,
  input  logic [KEY_ADDR_WIDTH-1:0] key_addr_i,
  input  logic [TEXT_WIDTH-1:0]     key_i,
  output logic                      key_err_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [TEXT_WIDTH-1:0]     state_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [TEXT_WIDTH-1:0]     state_o,
  output logic [KEY_ADDR_WIDTH-1:0] round_o,
  output logic                      last_o
);

  localparam logic [KEY_ADDR_WIDTH-1:0] LAST_RND =
    KEY_ADDR_WIDTH'(NUM_ROUNDS);

  logic [TEXT_WIDTH-1:0]     key_q [NUM_ROUNDS+1];
  logic [NUM_ROUNDS:0]       mask_q;
  logic [NUM_ROUNDS:0]       mask_d;
  logic [KEY_ADDR_WIDTH-1:0] rnd_q;
  logic                      key_err_q;
  logic                      key_ok;
  logic                      accept;
  buf_entry_t                push_entry;
  buf_entry_t                head;

  // Keys may only change between blocks, never mid-decrypt.
  assign key_ok = key_we_i && (rnd_q == LAST_RND) &&
                  (key_addr_i <= LAST_RND);
  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    mask_d = mask_q;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (key_ok && key_addr_i == KEY_ADDR_WIDTH'(i)) mask_d[i] = 1'b1;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.state = state_i ^ key_q[rnd_q];
    push_entry.round = rnd_q;
    push_entry.last  = (rnd_q == '0);
  end

  // Key store is not reset; the mask gates its use.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (key_ok && key_addr_i == KEY_ADDR_WIDTH'(i)) key_q[i] <= key_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q    <= '0;
      rnd_q     <= LAST_RND;
      key_err_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      key_err_q <= key_we_i & ~key_ok;
      if (accept) rnd_q <= (rnd_q == '0) ? LAST_RND : rnd_q - 1'b1;
    end
  end

  aes_skid_fifo #(
    .WIDTH($bits(buf_entry_t))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .allow_i     (&mask_d),
    .push_i      (accept),
    .data_i      (push_entry),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (head)
  );

  assign key_err_o = key_err_q;
  assign state_o   = head.state;
  assign round_o   = head.round;
  assign last_o    = head.last;

endmodule
